seg7_scan_driver: RTL

- Parametrised multi-digit 7-segment display driver.
- Captures a packed BCD word, decodes each digit to segments a..g, and time-multiplexes the digits onto one shared segment bus with a one-hot digit select.
- Sits between the datapath (counters, results) and the board display pins.
- Adds double-buffered loading (no tearing), an inter-digit blanking gap (anti-ghosting) and blank codes for non-BCD values.

---
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed multi-digit 7-segment scan driver
//
// Purpose: captures a packed BCD word into a pending buffer and moves it to
// the display buffer only on a frame boundary, so a frame never shows a mix
// of old and new digits. Each digit is decoded to segments a..g and shown in
// its own time slot on a shared segment bus. Every slot starts with a short
// all-off gap to stop the previous digit ghosting onto the next one.
//
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading zeros
// (digit 0 is never blanked).
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_bcd_in        packed BCD, digit k = [4k+3:4k], digit 0 least significant
//   i_load          one-cycle strobe, captures i_bcd_in into the pending buffer
//   o_seg_out       segments active high, [6]=a .. [0]=g
//   o_dig_sel       one-hot digit enable, active high
//   o_frame_start   pulse on the first output cycle of digit 0's slot
//   o_pending       loaded data not yet moved to the display buffer
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
  input  logic                    i_load,
  output logic [6:0]              o_seg_out,
  output logic [NUM_DIGITS-1:0]   o_dig_sel,
  output logic                    o_frame_start,
  output logic                    o_pending
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [4*NUM_DIGITS-1:0] r_disp;

  logic [3:0]              w_digit;
  logic                    w_lz_sel;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_div_wrap;
  logic                    w_xfer;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'h7E;
      4'd1:    f_decode = 7'h30;
      4'd2:    f_decode = 7'h6D;
      4'd3:    f_decode = 7'h79;
      4'd4:    f_decode = 7'h33;
      4'd5:    f_decode = 7'h5B;
      4'd6:    f_decode = 7'h5F;
      4'd7:    f_decode = 7'h70;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h7B;
      default: f_decode = 7'h00;
    endcase
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // w_lz[k] is set when digit k and every more-significant digit are zero.
  logic [NUM_DIGITS-1:0] w_lz;

  always_comb begin
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_run   = v_run & (r_disp[4*k +: 4] == 4'd0);
      w_lz[k] = v_run;
    end
    w_lz[0] = 1'b0;
  end
`endif

  // Mux the digit (and its leading-zero flag) for the current slot.
  always_comb begin
    w_digit  = 4'd0;
    w_lz_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_digit = r_disp[4*k +: 4];
`ifdef SEG7_LZ_BLANK_EN
        w_lz_sel = w_lz[k];
`endif
      end
    end
  end

  assign w_onehot   = NUM_DIGITS'(1) << r_idx;
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_xfer     = w_div_wrap && (r_idx == IDX_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt     <= '0;
      r_idx         <= '0;
      r_pend        <= '0;
      r_disp        <= '0;
      o_pending     <= 1'b0;
      o_seg_out     <= 7'h00;
      o_dig_sel     <= '0;
      o_frame_start <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // Outputs follow the current slot state, one cycle late. They are
      // decoded from r_disp before any transfer this cycle, so the last
      // cycle of a frame still shows the old data.
      o_frame_start <= (r_div_cnt == '0) && (r_idx == '0);
      if (r_div_cnt < BLANK_END) begin
        o_dig_sel <= '0;
        o_seg_out <= 7'h00;
      end else begin
        o_dig_sel <= w_onehot;
        o_seg_out <= w_lz_sel ? 7'h00 : f_decode(w_digit);
      end

      // A load landing on the transfer cycle goes straight to the display
      // buffer so it is not held back a whole frame.
      if (w_xfer) begin
        if (i_load) begin
          r_disp <= i_bcd_in;
          r_pend <= i_bcd_in;
        end else if (o_pending) begin
          r_disp <= r_pend;
        end
        o_pending <= 1'b0;
      end else if (i_load) begin
        r_pend    <= i_bcd_in;
        o_pending <= 1'b1;
      end
    end
  end

endmodule
